serial_add_sub_ctrl: RTL and testbench

Bit-serial add/subtract controller that sequences a single 1-bit full adder/subtractor cell over a WIDTH-bit operand pair, LSB first, one bit per clock. It latches operands and mode on a start request and walks the carry/borrow chain through an internal carry register. It returns a registered WIDTH-bit result with final carry (add) or borrow (sub) and a one-cycle done pulse. It sits between a requester issuing arithmetic commands and the bit-level add/sub cell.

---
 rtl/serial_add_sub_ctrl.sv | 119 +++++++++++
 tb/tb_serial_add_sub_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial add/subtract controller, LSB first, one bit per clock.
// Ports: clk, rst (sync, active-high), start/en/a/b request;
// busy, done pulse, result, cout (carry or borrow), ovf.
// ovf exists only when SERIAL_ADD_SUB_OVF_EN is defined.
module serial_add_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADD_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] sh;
  logic             mode;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             ai;
  logic             bi;
  logic             s;
  logic             cn;
  logic [WIDTH-1:0] sh_nx;

  // One full adder/subtractor cell; mode picks carry or borrow.
  always_comb begin
    ai    = ra[0];
    bi    = rb[0];
    s     = ai ^ bi ^ c;
    cn    = mode ? ((ai & bi) | ((ai ^ bi) & c))
                 : ((~ai & bi) | (~(ai ^ bi) & c));
    sh_nx = {s, sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      sh     <= '0;
      mode   <= 1'b0;
      c      <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            mode  <= en;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          sh  <= sh_nx;
          c   <= cn;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Result is published in one shot so
            // partial shifts never appear on it.
            result <= sh_nx;
            cout   <= cn;
`ifdef SERIAL_ADD_SUB_OVF_EN
            // c holds the carry into the MSB here.
            ovf    <= c ^ cn;
`endif
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Directed self-checking bench for serial_add_sub_ctrl.
// Drives and samples 1ns after each rising edge.
module tb_serial_add_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_add_sub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .en     (en),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
`ifdef SERIAL_ADD_SUB_OVF_EN
    .ovf    (ovf),
`endif
    .cout   (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion.
  // meddle: change inputs and hold start during RUN/DONE.
  task automatic run_op(input string tag,
                        input logic m,
                        input logic [W-1:0] va,
                        input logic [W-1:0] vb,
                        input logic [W-1:0] er,
                        input logic ec,
                        input logic eo,
                        input logic meddle);
    int edge_n;
    int nbusy;
    int ndone;
    start = 1'b1;
    en    = m;
    a     = va;
    b     = vb;
    step();
    if (meddle) begin
      en = ~m;
      a  = 8'hFF;
      b  = 8'hFF;
    end else begin
      start = 1'b0;
    end
    edge_n = 0;
    nbusy  = 0;
    ndone  = 0;
    while (!done && edge_n < 20) begin
      if (busy) nbusy++;
      step();
      edge_n++;
    end
    if (done) ndone++;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, edge_n, W);
    chk({tag, "_busycyc"}, nbusy, W);
    chk({tag, "_busy0"}, busy, 0);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADD_SUB_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) chk({tag, "_eo"}, eo, 0);
`endif
    step();
    if (done) ndone++;
    start = 1'b0;
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_busyidle"}, busy, 0);
    chk({tag, "_reshold"}, result, er);
  endtask

  initial begin
    int d1;
    int d2;
    int d3;
    int k;
    int nd;
    logic bad;
    rst   = 1'b1;
    start = 1'b0;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_cout", cout, 0);
`ifdef SERIAL_ADD_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif

    run_op("add7f01", 1, 8'h7F, 8'h01, 8'h80, 0, 1, 0);
    run_op("sub0001", 0, 8'h00, 8'h01, 8'hFF, 1, 0, 0);
    run_op("sub8001", 0, 8'h80, 8'h01, 8'h7F, 0, 1, 0);
    run_op("addff01", 1, 8'hFF, 8'h01, 8'h00, 1, 0, 0);
    run_op("ignore", 1, 8'h05, 8'h03, 8'h08, 0, 0, 1);

    // Abort mid-run just before bit 4 is processed.
    start = 1'b1;
    en    = 1'b1;
    a     = 8'h55;
    b     = 8'h0F;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", result, 0);
    chk("abort_cout", cout, 0);
    nd = 0;
    repeat (12) begin
      step();
      if (done) nd++;
    end
    chk("abort_nodone", nd, 0);
    run_op("sub1020", 0, 8'h10, 8'h20, 8'hF0, 1, 0, 0);

    // Back-to-back with start held high.
    start = 1'b1;
    en    = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    step();
    a   = 8'h10;
    d1  = -1;
    d2  = -1;
    d3  = -1;
    bad = 1'b0;
    for (k = 1; k <= 30; k++) begin
      step();
      if (done) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) begin
          d2 = k;
          chk("b2b_res2", result, 8'h12);
        end else if (d3 < 0) d3 = k;
      end else if (d1 >= 0 && d2 < 0) begin
        if (result !== 8'h03) bad = 1'b1;
      end
    end
    start = 1'b0;
    chk("b2b_first", d1, W);
    chk("b2b_gap1", d2 - d1, W + 2);
    chk("b2b_gap2", d3 - d2, W + 2);
    chk("b2b_hold", bad, 0);
    repeat (12) step();
    chk("end_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
